// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the imem handshake, owns PCF and the IF/ID register.
// Optional ack-timeout/retry logic is enabled with `define FETCH_TIMEOUT_EN.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC       = 32'h00000000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        StallD,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PcPlus4D,
   output logic        ValidD,
   output logic        fetch_err
);

   localparam logic [31:0] NOP = 32'h00000013;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

   state_t      state, stateNext;
   logic [31:0] pcF, pcNext, pcPlus4F;
   logic [31:0] pendPc, pendNext;
   logic [31:0] holdInstr, holdPc, holdPcPlus4;
   logic        doFlush, doCapture, doBubble, doHoldLoad, doHoldOut;
   logic        retry, ackEff;

   assign pcPlus4F  = pcF + 32'd4;
   assign imem_addr = pcF;
   // During a retry gap no request is outstanding, so any ack is not ours.
   assign ackEff    = imem_ack & ~retry;

`ifdef FETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] waitCnt;
   logic          waiting;

   assign waiting   = (state == FETCH || state == DISCARD) && !retry && !imem_ack;
   assign fetch_err = retry;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         waitCnt <= '0;
         retry   <= 1'b0;
      end else begin
         retry <= 1'b0;
         if (!waiting) begin
            waitCnt <= '0;
         end else if (waitCnt == CW'(TIMEOUT_CYCLES - 1)) begin
            waitCnt <= '0;
            retry   <= 1'b1;
         end else begin
            waitCnt <= waitCnt + CW'(1);
         end
      end
   end
`else
   assign retry     = 1'b0;
   assign fetch_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext  = state;
      pcNext     = pcF;
      pendNext   = pendPc;
      doFlush    = 1'b0;
      doCapture  = 1'b0;
      doBubble   = 1'b0;
      doHoldLoad = 1'b0;
      doHoldOut  = 1'b0;
      imem_req   = 1'b0;
      case (state)
         IDLE: stateNext = FETCH;
         FETCH: begin
            imem_req = ~retry;
            if (PCSrcE) begin
               doFlush = 1'b1;
               // Nothing outstanding (word returned or retry gap): redirect at once.
               if (ackEff || retry) begin
                  pcNext = PCTargetE;
               end else begin
                  pendNext  = PCTargetE;
                  stateNext = DISCARD;
               end
            end else if (ackEff) begin
               pcNext = pcPlus4F;
               if (StallD) begin
                  doHoldLoad = 1'b1;
                  stateNext  = HOLD;
               end else begin
                  doCapture = 1'b1;
               end
            end else if (!StallD) begin
               doBubble = 1'b1;
            end
         end
         HOLD: begin
            if (PCSrcE) begin
               doFlush   = 1'b1;
               pcNext    = PCTargetE;
               stateNext = FETCH;
            end else if (!StallD) begin
               doHoldOut = 1'b1;
               stateNext = FETCH;
            end
         end
         DISCARD: begin
            imem_req = ~retry;
            if (PCSrcE) pendNext = PCTargetE;
            if (ackEff) begin
               pcNext    = PCSrcE ? PCTargetE : pendPc;
               stateNext = FETCH;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcF         <= RESET_PC;
         pendPc      <= '0;
         holdInstr   <= '0;
         holdPc      <= '0;
         holdPcPlus4 <= '0;
         InstrD      <= '0;
         PCD         <= '0;
         PcPlus4D    <= '0;
         ValidD      <= 1'b0;
      end else begin
         pcF    <= pcNext;
         pendPc <= pendNext;
         if (doHoldLoad) begin
            holdInstr   <= imem_rdata;
            holdPc      <= pcF;
            holdPcPlus4 <= pcPlus4F;
         end
         if (doFlush) begin
            InstrD   <= NOP;
            PCD      <= '0;
            PcPlus4D <= '0;
            ValidD   <= 1'b0;
         end else if (doCapture) begin
            InstrD   <= imem_rdata;
            PCD      <= pcF;
            PcPlus4D <= pcPlus4F;
            ValidD   <= 1'b1;
         end else if (doHoldOut) begin
            InstrD   <= holdInstr;
            PCD      <= holdPc;
            PcPlus4D <= holdPcPlus4;
            ValidD   <= 1'b1;
         end else if (doBubble) begin
            ValidD <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: startup, ack delay, stall/hold, redirects, wrap, timeout, reset abort.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        PCSrcE = 1'b0;
   logic [31:0] PCTargetE = '0;
   logic        StallD = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata;
   logic [31:0] InstrD, PCD, PcPlus4D;
   logic        ValidD, fetch_err;

   int errors = 0;
   int checks = 0;
   logic expErr, expReqGap;

   // Memory returns a recognisable word per address: addr ^ DEAD0000.
   assign imem_rdata = imem_addr ^ 32'hDEAD0000;

   fetch_ctrl #(.RESET_PC(32'h00000000), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .InstrD(InstrD), .PCD(PCD), .PcPlus4D(PcPlus4D), .ValidD(ValidD), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ack, input logic stall, input logic src, input logic [31:0] tgt);
      imem_ack  = ack;
      StallD    = stall;
      PCSrcE    = src;
      PCTargetE = tgt;
   endtask

   initial begin
`ifdef FETCH_TIMEOUT_EN
      expErr    = 1'b1;
      expReqGap = 1'b0;
`else
      expErr    = 1'b0;
      expReqGap = 1'b1;
`endif
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick(); tick();
      check("rst_req",   {31'b0, imem_req}, 32'h0);
      check("rst_valid", {31'b0, ValidD}, 32'h0);
      check("rst_instr", InstrD, 32'h0);
      check("rst_pcd",   PCD, 32'h0);
      check("rst_err",   {31'b0, fetch_err}, 32'h0);
      check("rst_addr",  imem_addr, 32'h0);

      rst = 1'b1;                                     // cycle 1: IDLE bubble
      check("c1_req", {31'b0, imem_req}, 32'h0);
      tick();                                         // cycle 2: FETCH @0
      check("c2_req",   {31'b0, imem_req}, 32'h1);
      check("c2_valid", {31'b0, ValidD}, 32'h0);
      check("c2_addr",  imem_addr, 32'h0);
      tick();                                         // cycle 3
      check("c3_valid", {31'b0, ValidD}, 32'h1);
      check("c3_pcd",   PCD, 32'h0);
      check("c3_instr", InstrD, 32'hDEAD0000);
      check("c3_pc4",   PcPlus4D, 32'h4);
      tick(); check("c4_pcd", PCD, 32'h4);
      tick(); check("c5_pcd", PCD, 32'h8);
      tick();                                         // cycle 6: addr 0x10, ack delayed
      check("c6_pcd", PCD, 32'hC);
      check("c6_addr", imem_addr, 32'h10);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("dly_addr",  imem_addr, 32'h10);
         check("dly_valid", {31'b0, ValidD}, 32'h0);
         check("dly_pcd",   PCD, 32'hC);
         check("dly_req",   {31'b0, imem_req}, 32'h1);
      end
      tick();                                         // cycle 9: ack arrives
      check("c9_addr", imem_addr, 32'h10);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      check("c10_valid", {31'b0, ValidD}, 32'h1);
      check("c10_pcd",   PCD, 32'h10);
      check("c10_instr", InstrD, 32'hDEAD0010);
      check("c10_addr",  imem_addr, 32'h14);
      tick(); tick(); tick();                         // cycle 13: addr 0x20
      check("c13_addr", imem_addr, 32'h20);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      tick();                                         // cycle 14: HOLD
      check("hold_req", {31'b0, imem_req}, 32'h0);
      check("hold_pcd", PCD, 32'h1C);
      check("hold_valid", {31'b0, ValidD}, 32'h1);
      tick();                                         // cycle 15: still HOLD
      check("hold2_req", {31'b0, imem_req}, 32'h0);
      check("hold2_addr", imem_addr, 32'h24);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick();                                         // cycle 16: buffer released
      check("rel_pcd",   PCD, 32'h20);
      check("rel_instr", InstrD, 32'hDEAD0020);
      check("rel_pc4",   PcPlus4D, 32'h24);
      check("rel_addr",  imem_addr, 32'h24);
      check("rel_req",   {31'b0, imem_req}, 32'h1);
      tick(); tick(); tick();                         // cycle 19: addr 0x30
      check("c19_addr", imem_addr, 32'h30);
      drive(1'b0, 1'b0, 1'b1, 32'h100);
      tick();                                         // cycle 20: DISCARD
      check("dis_instr", InstrD, 32'h13);
      check("dis_valid", {31'b0, ValidD}, 32'h0);
      check("dis_pcd",   PCD, 32'h0);
      check("dis_pc4",   PcPlus4D, 32'h0);
      check("dis_addr",  imem_addr, 32'h30);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      check("dis2_valid", {31'b0, ValidD}, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick();                                         // cycle 22
      check("tgt_addr",  imem_addr, 32'h100);
      check("tgt_valid", {31'b0, ValidD}, 32'h0);
      tick();                                         // cycle 23
      check("tgt_pcd", PCD, 32'h100);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      tick();                                         // cycle 24: HOLD with 0x104 buffered
      check("h2_req", {31'b0, imem_req}, 32'h0);
      drive(1'b1, 1'b1, 1'b1, 32'h200);
      tick();                                         // cycle 25: flushed out of HOLD
      check("hf_instr", InstrD, 32'h13);
      check("hf_valid", {31'b0, ValidD}, 32'h0);
      check("hf_addr",  imem_addr, 32'h200);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick();                                         // cycle 26
      check("hf_pcd", PCD, 32'h200);
      drive(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC);
      tick();                                         // cycle 27: redirect with ack
      check("rd_valid", {31'b0, ValidD}, 32'h0);
      check("rd_instr", InstrD, 32'h13);
      check("rd_addr",  imem_addr, 32'hFFFFFFFC);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick();                                         // cycle 28: wrap
      check("wr_pcd",  PCD, 32'hFFFFFFFC);
      check("wr_pc4",  PcPlus4D, 32'h0);
      check("wr_addr", imem_addr, 32'h0);
      drive(1'b0, 1'b0, 1'b1, 32'h300);
      tick();
      check("dd_addr", imem_addr, 32'h0);
      drive(1'b0, 1'b0, 1'b1, 32'h400);
      tick();
      check("dd_valid", {31'b0, ValidD}, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick();                                         // cycle 31: latest pend wins
      check("dd_tgt", imem_addr, 32'h400);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      tick(); tick(); tick();                         // cycle 34: 4th waiting cycle
      check("to_req4", {31'b0, imem_req}, 32'h1);
      check("to_err4", {31'b0, fetch_err}, 32'h0);
      tick();                                         // cycle 35
      check("to_err",  {31'b0, fetch_err}, {31'b0, expErr});
      check("to_req",  {31'b0, imem_req}, {31'b0, expReqGap});
      check("to_addr", imem_addr, 32'h400);
      tick();                                         // cycle 36
      check("to_err_end", {31'b0, fetch_err}, 32'h0);
      check("to_rereq",   {31'b0, imem_req}, 32'h1);
      check("to_readdr",  imem_addr, 32'h400);

      rst = 1'b0;
      #1;
      check("ar_req",  {31'b0, imem_req}, 32'h0);
      check("ar_addr", imem_addr, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      rst = 1'b1;
      check("ar_idle_req", {31'b0, imem_req}, 32'h0);
      tick();
      check("ar_late_ack_valid", {31'b0, ValidD}, 32'h0);
      check("ar_fetch_req", {31'b0, imem_req}, 32'h1);
      tick();
      check("ar_pcd0", PCD, 32'h0);
      check("ar_valid", {31'b0, ValidD}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the ack-wait limit, used only with FETCH_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 PCSrcE  in  1  branch/jump redirect from Execute, one cycle per redirect.
REQ-006 PCTargetE  in  32  redirect target, valid when PCSrcE=1.
REQ-007 StallD  in  1  hazard-unit stall; IF/ID contents must hold.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  request address, equal to PCF.
REQ-010 imem_ack  in  1  memory response valid; completes the request in that cycle.
REQ-011 imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-012 InstrD, PCD, PcPlus4D  out  32 each  IF/ID register outputs.
REQ-013 ValidD  out  1  InstrD holds a real fetched instruction.
REQ-014 fetch_err  out  1  one-cycle pulse on ack timeout.

Function
REQ-015 SHALL implement states IDLE, FETCH, HOLD and DISCARD, with IDLE entered on reset.
REQ-016 IDLE: imem_req=0; SHALL always go to FETCH on the next edge, giving a one-cycle bubble after reset release.
REQ-017 FETCH: imem_req=1 and imem_addr=PCF, both held stable until imem_ack.
REQ-018 FETCH, ack=1, PCSrcE=0, StallD=0: IF/ID <= {imem_rdata, PCF, PCF+4}, ValidD<=1, PCF<=PCF+4; stay in FETCH.
REQ-019 FETCH, ack=1, PCSrcE=0, StallD=1: capture {imem_rdata, PCF, PCF+4} into the hold buffer, PCF<=PCF+4, IF/ID unchanged; go to HOLD.
REQ-020 FETCH, ack=0, PCSrcE=0: when StallD=0, ValidD<=0 (bubble, data fields unchanged); when StallD=1, IF/ID holds.
REQ-021 FETCH, PCSrcE=1, ack=1: drop the returned word, PCF<=PCTargetE, flush IF/ID; stay in FETCH.
REQ-022 FETCH, PCSrcE=1, ack=0: latch PCTargetE into pend_pc, flush IF/ID; go to DISCARD.
REQ-023 Flush SHALL set InstrD=32'h00000013 (NOP), PCD=0, PcPlus4D=0 and ValidD=0, and SHALL override StallD.
REQ-024 HOLD: imem_req=0. When StallD=0, IF/ID <= hold buffer, ValidD<=1, go to FETCH; when StallD=1, remain in HOLD.
REQ-025 HOLD with PCSrcE=1: discard the buffer, PCF<=PCTargetE, flush IF/ID, go to FETCH; PCSrcE takes priority over StallD.
REQ-026 DISCARD: imem_req=1 with the old PCF; a further PCSrcE SHALL overwrite pend_pc.
REQ-027 DISCARD on ack: drop the returned word, PCF<=pend_pc (or PCTargetE if PCSrcE=1 in the same cycle), go to FETCH.
REQ-028 DISCARD: ValidD SHALL remain 0.
REQ-029 PC arithmetic SHALL be modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
REQ-030 Latency: an ack in cycle N with no stall SHALL make InstrD/ValidD visible in cycle N+1.

Reset
REQ-031 While rst=0: state=IDLE, PCF=RESET_PC, imem_req=0, InstrD=PCD=PcPlus4D=0, ValidD=0, fetch_err=0, hold buffer and pend_pc cleared, timeout counter=0.
REQ-032 Reset asserted mid-request SHALL abandon the request immediately; a late imem_ack after reset release and before FETCH SHALL be ignored.

Configuration
REQ-033 Macro FETCH_TIMEOUT_EN.
- Defined: a counter SHALL increment each cycle in FETCH or DISCARD while ack=0.
- On reaching TIMEOUT_CYCLES: pulse fetch_err for one cycle, deassert imem_req for one cycle, reset the counter, then re-request the same PCF (in DISCARD, re-request the old PCF).
- Undefined: wait indefinitely; fetch_err tied to 0; no counter logic.

Verification
REQ-034 Reset release with ack tied 1 -> imem_req high from cycle 2; PCD sequence 0,4,8,...; ValidD=1 from cycle 3.
REQ-035 Ack delayed 3 cycles at PC=0x10 -> imem_addr stable at 0x10 for 4 cycles; ValidD=0 bubbles; InstrD valid with PCD=0x10 one cycle after ack.
REQ-036 StallD=1 at ack for PC=0x20, held 2 cycles -> HOLD with imem_req=0; after release, PCD=0x20 and next fetch address=0x24.
REQ-037 PCSrcE=1, target 0x100, during outstanding request at 0x30; ack 2 cycles later -> 0x30 word dropped, ValidD=0, next imem_addr=0x100.
REQ-038 PCSrcE with StallD=1 in HOLD -> InstrD=0x00000013, ValidD=0, fetch resumes at target.
REQ-039 With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never returns -> fetch_err pulse after 4 waiting cycles, imem_req low for 1 cycle, same address re-requested.
